// File: rtl/samples_delay_line.sv
// Per-channel circular sample history with a single shared RAM.
// Each accepted sample triggers a NumTaps readout, newest first.
module samples_delay_line #(
    parameter int DataWidth   = 18,
    parameter int Depth       = 128,
    parameter int NumTaps     = 64,
    parameter int NumChannels = 2,
    localparam int ChW   = (NumChannels > 1) ? $clog2(NumChannels) : 1,
    localparam int TapW  = (NumTaps > 1) ? $clog2(NumTaps) : 1,
    localparam int PtrW  = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [ChW-1:0]       in_ch_i,
    input  logic [DataWidth-1:0] in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_data_o,
    output logic [TapW-1:0]      out_tap_o,
    output logic [ChW-1:0]       out_ch_o,
    output logic                 out_last_o,
    output logic                 busy_o
);

    localparam int CntW  = $clog2(NumTaps + 1);
    localparam int AddrW = (NumChannels * Depth > 1) ? $clog2(NumChannels * Depth) : 1;

    typedef enum logic {
        IDLE,
        SEQ
    } state_t;

    state_t state_q, state_d;

    logic [PtrW-1:0] wr_ptr_q [NumChannels];
    logic [PtrW-1:0] wr_ptr_d [NumChannels];
    logic [PtrW:0]   fill_q   [NumChannels];
    logic [PtrW:0]   fill_d   [NumChannels];

    logic [ChW-1:0]  ch_q, ch_d;
    logic [CntW-1:0] iss_q, iss_d;

    logic            out_valid_q, out_valid_d;
    logic [TapW-1:0] out_tap_q, out_tap_d;
    logic [ChW-1:0]  out_ch_q, out_ch_d;
    logic            out_last_q, out_last_d;
    logic            zero_q, zero_d;

    logic [DataWidth-1:0] mem [NumChannels * Depth];
    logic [DataWidth-1:0] rd_q;

    logic             ch_ok;
    logic [ChW-1:0]   wr_ch;
    logic             accept;
    logic             out_fire;
    logic             load;
    logic [PtrW-1:0]  rd_ptr;
    logic [AddrW-1:0] rd_addr;
    logic [AddrW-1:0] wr_addr;
    logic             wr_en;

    assign in_ready_o = (state_q == IDLE) && !flush_i;
    assign ch_ok      = int'(in_ch_i) < NumChannels;
    assign wr_ch      = ch_ok ? in_ch_i : '0;
    assign accept     = in_valid_i && in_ready_o && ch_ok;
    assign wr_en      = accept && !rst_i;
    assign out_fire   = out_valid_q && out_ready_i;

    // A read is issued only when the output register will be free next cycle,
    // so the read register never needs a skid buffer.
    assign load = (state_q == SEQ) && (int'(iss_q) < NumTaps)
                  && (!out_valid_q || out_ready_i);

    assign rd_ptr  = wr_ptr_q[ch_q] - PtrW'(1) - PtrW'(iss_q);
    assign rd_addr = AddrW'(int'(ch_q) * Depth + int'(rd_ptr));
    assign wr_addr = AddrW'(int'(wr_ch) * Depth + int'(wr_ptr_q[wr_ch]));

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        ch_d        = ch_q;
        iss_d       = iss_q;
        out_valid_d = out_valid_q;
        out_tap_d   = out_tap_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        zero_d      = zero_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
            if (out_last_q) begin
                state_d = IDLE;
            end
        end

        if (load) begin
            out_valid_d = 1'b1;
            out_tap_d   = TapW'(iss_q);
            out_ch_d    = ch_q;
            out_last_d  = int'(iss_q) == NumTaps - 1;
            zero_d      = int'(iss_q) >= int'(fill_q[ch_q]);
            iss_d       = iss_q + CntW'(1);
        end

        if (accept) begin
            wr_ptr_d[wr_ch] = wr_ptr_q[wr_ch] + PtrW'(1);
            if (int'(fill_q[wr_ch]) != Depth) begin
                fill_d[wr_ch] = fill_q[wr_ch] + (PtrW+1)'(1);
            end
            ch_d    = wr_ch;
            iss_d   = '0;
            state_d = SEQ;
        end

        if (flush_i) begin
            for (int i = 0; i < NumChannels; i++) begin
                wr_ptr_d[i] = '0;
                fill_d[i]   = '0;
            end
            iss_d       = '0;
            out_valid_d = 1'b0;
            state_d     = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            for (int i = 0; i < NumChannels; i++) begin
                wr_ptr_q[i] <= '0;
                fill_q[i]   <= '0;
            end
            ch_q        <= '0;
            iss_q       <= '0;
            out_valid_q <= 1'b0;
            out_tap_q   <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            ch_q        <= ch_d;
            iss_q       <= iss_d;
            out_valid_q <= out_valid_d;
            out_tap_q   <= out_tap_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
            zero_q      <= zero_d;
        end
    end

    // Storage is deliberately not reset; the read register holds during stalls.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= in_data_i;
        end
        if (load) begin
            rd_q <= mem[rd_addr];
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = (out_valid_q && !zero_q) ? rd_q : '0;
    assign out_tap_o   = out_tap_q;
    assign out_ch_o    = out_ch_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = (state_q == SEQ);

endmodule

// File: tb/tb_samples_delay_line.sv
// Scoreboard bench for samples_delay_line: a queue-based history model
// predicts every tap; a monitor compares taps on each output handshake.
module tb_samples_delay_line;

    localparam int DW  = 18;
    localparam int DEP = 8;
    localparam int NT  = 4;
    localparam int NCH = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [0:0]    in_ch = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [1:0]    out_tap;
    logic [0:0]    out_ch;
    logic          out_last;
    logic          busy;

    logic          in_valid3 = 1'b0;
    logic          in_ready3;
    logic [1:0]    in_ch3 = '0;
    logic [DW-1:0] in_data3 = '0;
    logic          out_valid3;
    logic [DW-1:0] out_data3;
    logic [1:0]    out_tap3;
    logic [1:0]    out_ch3;
    logic          out_last3;
    logic          busy3;

    samples_delay_line #(
        .DataWidth(DW), .Depth(DEP), .NumTaps(NT), .NumChannels(NCH)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_ch_i(in_ch), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_tap_o(out_tap),
        .out_ch_o(out_ch), .out_last_o(out_last), .busy_o(busy)
    );

    samples_delay_line #(
        .DataWidth(DW), .Depth(DEP), .NumTaps(NT), .NumChannels(3)
    ) u_dut3 (
        .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
        .in_valid_i(in_valid3), .in_ready_o(in_ready3),
        .in_ch_i(in_ch3), .in_data_i(in_data3),
        .out_valid_o(out_valid3), .out_ready_i(1'b1),
        .out_data_o(out_data3), .out_tap_o(out_tap3),
        .out_ch_o(out_ch3), .out_last_o(out_last3), .busy_o(busy3)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            tap;
        int            ch;
        bit            last;
    } exp_t;

    typedef logic [DW-1:0] sq_t[$];

    exp_t expq[$];
    sq_t  hist [NCH];
    int   checks = 0;
    int   errors = 0;
    bit   stall_mode = 1'b0;
    bit   ready_manual = 1'b0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Newest-first history per channel; taps past the history read as zero.
    task automatic model_push(int c, logic [DW-1:0] d);
        exp_t e;
        hist[c].push_front(d);
        if (hist[c].size() > DEP) void'(hist[c].pop_back());
        for (int k = 0; k < NT; k++) begin
            e.data = (k < hist[c].size()) ? hist[c][k] : '0;
            e.tap  = k;
            e.ch   = c;
            e.last = (k == NT - 1);
            expq.push_back(e);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) hist[c].delete();
        expq.delete();
    endtask

    task automatic push(int c, logic [DW-1:0] d);
        int n;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_ch    = 1'(c);
        in_data  = d;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (n == 200) begin
            chk("push_timeout", 0, 1);
        end else begin
            model_push(c, d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 2000 && expq.size() != 0; n++) @(negedge clk);
        chk("drain", expq.size(), 0);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (!ready_manual) begin
            out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    bit            stall_v = 1'b0;
    bit            last_seen = 1'b0;
    logic [DW-1:0] s_data;
    logic [1:0]    s_tap;
    logic [0:0]    s_ch;
    logic          s_last;

    always @(negedge clk) begin
        exp_t e;
        if (rst || flush) begin
            stall_v   = 1'b0;
            last_seen = 1'b0;
        end else begin
            if (last_seen) chk("in_ready_after_last", in_ready, 1);
            last_seen = 1'b0;
            if (stall_v) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, s_data);
                chk("hold_tap", out_tap, s_tap);
                chk("hold_ch", out_ch, s_ch);
                chk("hold_last", out_last, s_last);
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("unexpected_tap", 1, 0);
                end else begin
                    e = expq.pop_front();
                    chk("tap_data", out_data, e.data);
                    chk("tap_index", out_tap, e.tap);
                    chk("tap_ch", out_ch, e.ch);
                    chk("tap_last", out_last, e.last);
                    chk("tap_busy", busy, 1);
                end
                if (out_last) last_seen = 1'b1;
            end
            stall_v = out_valid && !out_ready;
            s_data  = out_data;
            s_tap   = out_tap;
            s_ch    = out_ch;
            s_last  = out_last;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", out_data, 0);
        chk("rst_tap", out_tap, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_last", out_last, 0);

        push(0, DW'(5));
        @(negedge clk);
        chk("latency_c1", out_valid, 0);
        @(negedge clk);
        chk("latency_c2", out_valid, 1);
        drain();

        for (int i = 1; i <= 10; i++) push(0, DW'(i));
        drain();

        for (int i = 1; i <= 3; i++) begin
            push(0, DW'(i));
            push(1, DW'(-i));
        end
        drain();

        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        model_clear();
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_valid", out_valid, 0);
        chk("flush_busy", busy, 0);

        stall_mode = 1'b1;
        for (int i = 1; i <= 4; i++) push(0, DW'(i));
        drain();
        stall_mode = 1'b0;

        ready_manual = 1'b1;
        out_ready = 1'b0;
        push(0, DW'(3));
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("flush_seq_start", out_valid, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_at_tap1", out_tap, 1);
        @(posedge clk);
        model_clear();
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_mid_valid", out_valid, 0);
        chk("flush_mid_busy", busy, 0);
        ready_manual = 1'b0;
        push(0, DW'(9));
        drain();

        stall_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push(int'($urandom_range(0, NCH - 1)), DW'($urandom));
        end
        drain();

        push(1, DW'(77));
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        model_clear();
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", in_ready, 1);
        chk("rst_mid_data", out_data, 0);
        push(1, DW'(8));
        drain();
        stall_mode = 1'b0;

        @(posedge clk);
        #1;
        in_valid3 = 1'b1;
        in_ch3    = 2'd3;
        in_data3  = DW'(55);
        @(negedge clk);
        chk("bad_ch_ready", in_ready3, 1);
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bad_ch_no_tap", out_valid3, 0);
            chk("bad_ch_busy", busy3, 0);
        end
        @(posedge clk);
        #1;
        in_valid3 = 1'b1;
        in_ch3    = 2'd2;
        in_data3  = DW'(7);
        @(negedge clk);
        chk("ch2_ready", in_ready3, 1);
        @(posedge clk);
        #1;
        in_valid3 = 1'b0;
        @(negedge clk);
        chk("ch2_lat1", out_valid3, 0);
        @(negedge clk);
        chk("ch2_valid", out_valid3, 1);
        chk("ch2_data", out_data3, 7);
        chk("ch2_tap", out_tap3, 0);
        chk("ch2_ch", out_ch3, 2);
        @(negedge clk);
        chk("ch2_tap1_zero", out_data3, 0);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/samples_delay_line.md
SAMPLES_DELAY_LINE -- requirements
Module: samples_delay_line

Interface
REQ-001 The block SHALL have parameter DataWidth, default 18, meaning the sample width in bits (two's complement).
REQ-002 The block SHALL have parameter Depth, default 128, meaning the history entries per channel; it SHALL be a power of two, at least 2.
REQ-003 The block SHALL have parameter NumTaps, default 64, meaning the taps read per input sample; valid range is 1..Depth.
REQ-004 The block SHALL have parameter NumChannels, default 2, meaning the number of independent channel histories; it SHALL be at least 1.
REQ-005 Derived widths SHALL be: ChW = max(1, clog2(NumChannels)), TapW = max(1, clog2(NumTaps)), PtrW = clog2(Depth).
REQ-006 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port flush_i, input, 1 bit: clears all histories and aborts any sequence in progress.
REQ-009 The block SHALL have port in_valid_i, input, 1 bit: input sample valid.
REQ-010 The block SHALL have port in_ready_o, output, 1 bit: the block accepts an input sample.
REQ-011 The block SHALL have port in_ch_i, input, ChW bits: channel of the input sample.
REQ-012 The block SHALL have port in_data_i, input, DataWidth bits: input sample.
REQ-013 The block SHALL have port out_valid_o, output, 1 bit: tap output valid.
REQ-014 The block SHALL have port out_ready_i, input, 1 bit: the consumer accepts the tap.
REQ-015 The block SHALL have port out_data_o, output, DataWidth bits: the history sample for the tap.
REQ-016 The block SHALL have port out_tap_o, output, TapW bits: tap index, where 0 is the newest sample.
REQ-017 The block SHALL have port out_ch_o, output, ChW bits: the channel of the sequence.
REQ-018 The block SHALL have port out_last_o, output, 1 bit: high on tap NumTaps-1.
REQ-019 The block SHALL have port busy_o, output, 1 bit: a tap sequence is in progress.

Function
REQ-020 Storage SHALL be a single RAM of NumChannels*Depth words with a 1-cycle registered read; the RAM contents SHALL NOT be reset.
REQ-021 Each channel SHALL hold a write pointer (PtrW bits, wraps Depth-1 -> 0) and a fill count (0..Depth, saturating at Depth).
REQ-022 The FSM SHALL have the states IDLE and SEQ; in_ready_o SHALL equal (state==IDLE && !flush_i).
REQ-023 When an input handshake occurs with a legal channel c, the block SHALL write in_data_i at address (c, wr_ptr[c]) in that cycle, increment wr_ptr[c] and fill[c], latch c, and move to SEQ.
REQ-024 When an input handshake occurs with in_ch_i >= NumChannels, the block SHALL drop the sample, change no state, and remain in IDLE.
REQ-025 In SEQ, tap k (k = 0..NumTaps-1, in ascending order) SHALL read address (c, (wr_ptr[c]-1-k) mod Depth), using the post-write pointer.
REQ-026 Tap k SHALL output 0 when k >= fill[c] (unfilled history), otherwise the stored word unchanged.
REQ-027 The first tap SHALL be valid 2 cycles after the input handshake cycle.
REQ-028 While out_ready_i stays high, the block SHALL deliver 1 tap per cycle.
REQ-029 Under any out_ready_i pattern, the block SHALL NOT drop, duplicate or reorder taps.
REQ-030 The outputs SHALL be stable while out_valid_o && !out_ready_i.
REQ-031 out_tap_o, out_ch_o and out_last_o SHALL be aligned with out_data_o.
REQ-032 On the out_last_o handshake, the FSM SHALL return to IDLE, and in_ready_o SHALL be 1 in the next cycle.
REQ-033 busy_o SHALL be 1 in SEQ and until the last tap handshake, and 0 otherwise.
REQ-034 When flush_i is high in any state, the next cycle SHALL have all wr_ptr = 0, all fill = 0, state IDLE and out_valid_o = 0; any pending taps SHALL be discarded.
REQ-035 When flush_i and in_valid_i are high together, the sample SHALL NOT be accepted.
REQ-036 When NumTaps == Depth and the history is full, tap Depth-1 SHALL return the oldest sample, and no tap SHALL return the new sample twice.
REQ-037 A channel's pointer and fill count SHALL be unaffected by samples on other channels.

Reset
REQ-038 When rst_i is high at a clock edge, all wr_ptr and fill SHALL become 0, the state SHALL become IDLE, out_valid_o, out_data_o, out_tap_o, out_ch_o, out_last_o and busy_o SHALL become 0, and in_ready_o SHALL be 1 after reset releases.
REQ-039 Reset SHALL take precedence over flush_i and over all handshakes, including in the middle of a sequence.

Verification (bench parameters: DataWidth 18, Depth 8, NumTaps 4, NumChannels 2)
REQ-040 Scenario: reset, then push ch0 value 5 with out_ready_i=1 -> taps 5,0,0,0, tap indices 0..3, out_last_o on tap 3, first tap 2 cycles after the push.
REQ-041 Scenario: push ch0 values 1..10 -> the last sequence is 10,9,8,7; the pointer has wrapped.
REQ-042 Scenario: alternate pushes ch0 1,2,3 and ch1 -1,-2,-3 -> the ch1 final sequence is -3,-2,-1,0 with out_ch_o=1; ch0 is unaffected.
REQ-043 Scenario: random out_ready_i stalls during a ch0 sequence 4,3,2,1 -> the same four taps in order, with the outputs held during stalls.
REQ-044 Scenario: flush_i asserted at tap 1 of a sequence -> out_valid_o is 0 next cycle; the next push of 9 yields 9,0,0,0.
REQ-045 Scenario: push in_ch_i=... out of range is not representable with 2 channels, so run NumChannels=3 with in_ch_i=3 -> handshake completes, no taps, busy_o stays 0.
